// File: rtl/cache_2way_if.sv
// CPU- and memory-side bus bundle for cache_2way.
// The cache takes the slave modport; the CPU/memory environment takes master.
interface cache_2way_if #(
    parameter int ADDR_W   = 13,
    parameter int OFFSET_W = 2
);
    localparam int LINE_W = 8 << OFFSET_W;

    logic [ADDR_W-1:0] addr_from_cpu;
    logic [7:0]        wdata_from_cpu;
    logic              rreq_from_cpu;
    logic              wreq_from_cpu;
    logic [LINE_W-1:0] rdata_from_mem;
    logic              rvalid_from_mem;
    logic              wack_from_mem;
    logic [7:0]        rdata_to_cpu;
    logic              hit_to_cpu;
    logic              rreq_to_mem;
    logic [ADDR_W-1:0] raddr_to_mem;
    logic              wreq_to_mem;
    logic [ADDR_W-1:0] waddr_to_mem;
    logic [7:0]        wdata_to_mem;

    modport slave (
        input  addr_from_cpu, wdata_from_cpu, rreq_from_cpu, wreq_from_cpu,
        input  rdata_from_mem, rvalid_from_mem, wack_from_mem,
        output rdata_to_cpu, hit_to_cpu,
        output rreq_to_mem, raddr_to_mem, wreq_to_mem, waddr_to_mem, wdata_to_mem
    );

    modport master (
        output addr_from_cpu, wdata_from_cpu, rreq_from_cpu, wreq_from_cpu,
        output rdata_from_mem, rvalid_from_mem, wack_from_mem,
        input  rdata_to_cpu, hit_to_cpu,
        input  rreq_to_mem, raddr_to_mem, wreq_to_mem, waddr_to_mem, wdata_to_mem
    );
endinterface

// File: rtl/cache_2way.sv
// 2-way set-associative, write-through, no-write-allocate byte cache with LRU replacement.
// Optional hit/miss statistics counters are enabled by defining CACHE_2WAY_STATS_EN.
module cache_2way #(
    parameter int ADDR_W   = 13,
    parameter int OFFSET_W = 2,
    parameter int INDEX_W  = 6
) (
    input  logic        clk,
    input  logic        reset,
`ifdef CACHE_2WAY_STATS_EN
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
`endif
    cache_2way_if.slave bus
);
    localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINE_W = 8 << OFFSET_W;
    localparam int SETS   = 1 << INDEX_W;

    typedef enum logic [2:0] {
        READY       = 3'd0,
        TAG_CHECK   = 3'd1,
        REFILL      = 3'd2,
        WRITE_CHECK = 3'd3,
        WMEM        = 3'd4
    } state_t;

    state_t state_r, state_next_s;

    logic [SETS-1:0]   valid0_r, valid1_r, lru_r;
    logic [TAG_W-1:0]  tag0_r  [SETS];
    logic [TAG_W-1:0]  tag1_r  [SETS];
    logic [LINE_W-1:0] data0_r [SETS];
    logic [LINE_W-1:0] data1_r [SETS];

    logic [OFFSET_W-1:0] offset_s;
    logic [INDEX_W-1:0]  index_s;
    logic [TAG_W-1:0]    tag_s;
    logic                hit0_s, hit1_s, hit_s, victim_s;
    logic [LINE_W-1:0]   hit_line_s;
    logic [7:0]          hit_byte_s;
    logic                hit_out_s, fill_s, wr_hit_s, lru_touch_s;
    logic                rreq_next_s, wreq_next_s;
    logic [ADDR_W-1:0]   raddr_next_s, waddr_next_s;
    logic [7:0]          wdata_next_s;
    logic                rreq_r, wreq_r;
    logic [ADDR_W-1:0]   raddr_r, waddr_r;
    logic [7:0]          wdata_r;

    assign offset_s   = bus.addr_from_cpu[OFFSET_W-1:0];
    assign index_s    = bus.addr_from_cpu[OFFSET_W +: INDEX_W];
    assign tag_s      = bus.addr_from_cpu[ADDR_W-1 -: TAG_W];
    assign hit0_s     = valid0_r[index_s] && (tag0_r[index_s] == tag_s);
    assign hit1_s     = valid1_r[index_s] && (tag1_r[index_s] == tag_s);
    assign hit_s      = hit0_s || hit1_s;
    // An empty way is always preferred; only a full set consults LRU.
    assign victim_s   = !valid0_r[index_s] ? 1'b0 :
                        (!valid1_r[index_s] ? 1'b1 : lru_r[index_s]);
    assign hit_line_s = hit0_s ? data0_r[index_s] : data1_r[index_s];
    assign hit_byte_s = hit_line_s[{offset_s, 3'b000} +: 8];

    // Next-state and cache-update strobes.
    always_comb begin
        state_next_s = state_r;
        hit_out_s    = 1'b0;
        fill_s       = 1'b0;
        wr_hit_s     = 1'b0;
        lru_touch_s  = 1'b0;
        case (state_r)
            READY: begin
                if (bus.rreq_from_cpu) begin
                    state_next_s = TAG_CHECK;
                end else if (bus.wreq_from_cpu) begin
                    state_next_s = WRITE_CHECK;
                end else begin
                    state_next_s = READY;
                end
            end
            TAG_CHECK: begin
                if (hit_s) begin
                    hit_out_s    = 1'b1;
                    lru_touch_s  = 1'b1;
                    state_next_s = READY;
                end else begin
                    state_next_s = REFILL;
                end
            end
            REFILL: begin
                if (bus.rvalid_from_mem) begin
                    fill_s       = 1'b1;
                    state_next_s = TAG_CHECK;
                end else begin
                    state_next_s = REFILL;
                end
            end
            WRITE_CHECK: begin
                wr_hit_s     = hit_s;
                lru_touch_s  = hit_s;
                state_next_s = WMEM;
            end
            WMEM: begin
                if (bus.wack_from_mem) begin
                    hit_out_s    = 1'b1;
                    state_next_s = READY;
                end else begin
                    state_next_s = WMEM;
                end
            end
            default: begin
                state_next_s = READY;
            end
        endcase
    end

    // Memory-side outputs are registered from the next state so they are live for the whole state.
    always_comb begin
        rreq_next_s  = (state_next_s == REFILL);
        wreq_next_s  = (state_next_s == WMEM);
        raddr_next_s = rreq_next_s ? {bus.addr_from_cpu[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}}
                                   : {ADDR_W{1'b0}};
        waddr_next_s = wreq_next_s ? bus.addr_from_cpu : {ADDR_W{1'b0}};
        wdata_next_s = wreq_next_s ? bus.wdata_from_cpu : 8'h00;
    end

    // State and memory-side output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= READY;
            rreq_r  <= 1'b0;
            raddr_r <= {ADDR_W{1'b0}};
            wreq_r  <= 1'b0;
            waddr_r <= {ADDR_W{1'b0}};
            wdata_r <= 8'h00;
        end else begin
            state_r <= state_next_s;
            rreq_r  <= rreq_next_s;
            raddr_r <= raddr_next_s;
            wreq_r  <= wreq_next_s;
            waddr_r <= waddr_next_s;
            wdata_r <= wdata_next_s;
        end
    end

    // Valid and LRU bookkeeping; LRU always ends up naming the way not just used.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid0_r <= {SETS{1'b0}};
            valid1_r <= {SETS{1'b0}};
            lru_r    <= {SETS{1'b0}};
        end else if (fill_s) begin
            if (victim_s) begin
                valid1_r[index_s] <= 1'b1;
            end else begin
                valid0_r[index_s] <= 1'b1;
            end
            lru_r[index_s] <= ~victim_s;
        end else if (lru_touch_s) begin
            lru_r[index_s] <= hit0_s;
        end
    end

    // Tag and line storage; left unreset because valid bits guard them.
    always_ff @(posedge clk) begin
        if (fill_s) begin
            if (victim_s) begin
                tag1_r[index_s]  <= tag_s;
                data1_r[index_s] <= bus.rdata_from_mem;
            end else begin
                tag0_r[index_s]  <= tag_s;
                data0_r[index_s] <= bus.rdata_from_mem;
            end
        end else if (wr_hit_s) begin
            if (hit0_s) begin
                data0_r[index_s][{offset_s, 3'b000} +: 8] <= bus.wdata_from_cpu;
            end else begin
                data1_r[index_s][{offset_s, 3'b000} +: 8] <= bus.wdata_from_cpu;
            end
        end
    end

    assign bus.hit_to_cpu   = hit_out_s;
    assign bus.rdata_to_cpu = (hit_out_s && (state_r == TAG_CHECK)) ? hit_byte_s : 8'h00;
    assign bus.rreq_to_mem  = rreq_r;
    assign bus.raddr_to_mem = raddr_r;
    assign bus.wreq_to_mem  = wreq_r;
    assign bus.waddr_to_mem = waddr_r;
    assign bus.wdata_to_mem = wdata_r;

`ifdef CACHE_2WAY_STATS_EN
    logic from_refill_r;
    logic count_hit_s, count_miss_s;

    assign count_hit_s  = hit_s && (((state_r == TAG_CHECK) && !from_refill_r) ||
                                    (state_r == WRITE_CHECK));
    assign count_miss_s = !hit_s && ((state_r == TAG_CHECK) || (state_r == WRITE_CHECK));

    // Statistics; the re-check after a refill is the tail of a miss, not a fresh hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            from_refill_r <= 1'b0;
            hit_cnt       <= 32'd0;
            miss_cnt      <= 32'd0;
        end else begin
            from_refill_r <= (state_r == REFILL);
            if (count_hit_s) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (count_miss_s) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_cache_2way.sv
// Directed self-checking bench for cache_2way: refill, LRU eviction, write-through,
// write miss without allocation and reset abandoning a refill.
module tb_cache_2way;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] mem [8192];
`ifdef CACHE_2WAY_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    cache_2way_if #(.ADDR_W(13), .OFFSET_W(2)) bus ();

    cache_2way #(.ADDR_W(13), .OFFSET_W(2), .INDEX_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef CACHE_2WAY_STATS_EN
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt),
`endif
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // CPU read with an inline memory responder answering after lat cycles of rreq_to_mem.
    task automatic do_read(input string tag, input logic [12:0] a, input bit exp_miss,
                           input int lat, input logic [7:0] exp_d);
        int cyc = 0;
        int rcyc = 0;
        bit done = 1'b0;
        logic [12:0] la;
        la = {a[12:2], 2'b00};
        @(negedge clk);
        bus.addr_from_cpu = a;
        bus.rreq_from_cpu = 1'b1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            bus.rvalid_from_mem = 1'b0;
            if (bus.hit_to_cpu) begin
                done = 1'b1;
                check({tag, ":data"}, 32'(bus.rdata_to_cpu), 32'(exp_d));
            end else if (bus.rreq_to_mem) begin
                rcyc++;
                if (rcyc == 1) begin
                    check({tag, ":raddr"}, 32'(bus.raddr_to_mem), 32'(la));
                end
                if (rcyc == lat) begin
                    bus.rdata_from_mem  = {mem[la + 13'd3], mem[la + 13'd2], mem[la + 13'd1], mem[la]};
                    bus.rvalid_from_mem = 1'b1;
                end
            end
        end
        bus.rvalid_from_mem = 1'b0;
        check({tag, ":done"}, 32'(done), 32'd1);
        check({tag, ":latency"}, 32'(cyc + 1), 32'(exp_miss ? 3 + lat : 2));
        check({tag, ":rreq_cycles"}, 32'(rcyc), 32'(exp_miss ? lat : 0));
        @(negedge clk);
        bus.rreq_from_cpu = 1'b0;
    endtask

    // CPU write; memory acknowledges after lat cycles of wreq_to_mem.
    task automatic do_write(input string tag, input logic [12:0] a, input logic [7:0] d,
                            input int lat);
        int cyc = 0;
        int wcyc = 0;
        bit done = 1'b0;
        bit bad_bus = 1'b0;
        bit saw_rreq = 1'b0;
        bit early_hit = 1'b0;
        @(negedge clk);
        bus.addr_from_cpu  = a;
        bus.wdata_from_cpu = d;
        bus.wreq_from_cpu  = 1'b1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.rreq_to_mem) saw_rreq = 1'b1;
            if (bus.hit_to_cpu) early_hit = 1'b1;
            if (bus.wreq_to_mem) begin
                wcyc++;
                if (bus.waddr_to_mem !== a || bus.wdata_to_mem !== d) bad_bus = 1'b1;
                if (wcyc == lat) begin
                    bus.wack_from_mem = 1'b1;
                    mem[a] = d;
                    #1;
                    check({tag, ":hit_on_wack"}, 32'(bus.hit_to_cpu), 32'd1);
                    done = 1'b1;
                end
            end
        end
        check({tag, ":done"}, 32'(done), 32'd1);
        check({tag, ":wreq_cycles"}, 32'(wcyc), 32'(lat));
        check({tag, ":waddr_wdata_held"}, 32'(bad_bus), 32'd0);
        check({tag, ":no_rreq"}, 32'(saw_rreq), 32'd0);
        check({tag, ":no_early_hit"}, 32'(early_hit), 32'd0);
        @(negedge clk);
        bus.wack_from_mem = 1'b0;
        bus.wreq_from_cpu = 1'b0;
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 8192; i++) mem[i] = 8'(i * 7 + 3);
        mem[13'h0104] = 8'hAA;
        mem[13'h0105] = 8'hBB;
        mem[13'h0106] = 8'hCC;
        mem[13'h0107] = 8'hDD;

        reset               = 1'b1;
        bus.addr_from_cpu   = 13'h0000;
        bus.wdata_from_cpu  = 8'h00;
        bus.rreq_from_cpu   = 1'b0;
        bus.wreq_from_cpu   = 1'b0;
        bus.rdata_from_mem  = 32'h0000_0000;
        bus.rvalid_from_mem = 1'b0;
        bus.wack_from_mem   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst:hit", 32'(bus.hit_to_cpu), 32'd0);
        check("rst:rdata", 32'(bus.rdata_to_cpu), 32'd0);
        check("rst:rreq", 32'(bus.rreq_to_mem), 32'd0);
        check("rst:raddr", 32'(bus.raddr_to_mem), 32'd0);
        check("rst:wreq", 32'(bus.wreq_to_mem), 32'd0);
        check("rst:waddr", 32'(bus.waddr_to_mem), 32'd0);
        check("rst:wdata", 32'(bus.wdata_to_mem), 32'd0);
`ifdef CACHE_2WAY_STATS_EN
        check("rst:hit_cnt", hit_cnt, 32'd0);
        check("rst:miss_cnt", miss_cnt, 32'd0);
`endif
        reset = 1'b0;

        // Cold miss: line 0x0104 refilled into way0, byte 1 = 0xBB.
        do_read("rd0105", 13'h0105, 1'b1, 2, 8'hBB);
`ifdef CACHE_2WAY_STATS_EN
        check("cnt0:hit", hit_cnt, 32'd0);
        check("cnt0:miss", miss_cnt, 32'd1);
`endif
        // Same set (index 1): tag 2 fills way1, tag 1 still hits.
        do_read("rd0104a", 13'h0104, 1'b0, 1, 8'hAA);
        do_read("rd0204a", 13'h0204, 1'b1, 1, mem[13'h0204]);
        do_read("rd0104b", 13'h0104, 1'b0, 1, 8'hAA);
        // Tag 3 evicts LRU way1 (tag 2); tag 1 survives, tag 2 must refetch.
        do_read("rd0304", 13'h0304, 1'b1, 3, mem[13'h0304]);
        do_read("rd0104c", 13'h0104, 1'b0, 1, 8'hAA);
        do_read("rd0204b", 13'h0204, 1'b1, 1, mem[13'h0204]);

        // Write hit with slow ack, then read back from the cache.
        do_write("wr0106", 13'h0106, 8'h5A, 3);
        do_read("rd0106", 13'h0106, 1'b0, 1, 8'h5A);

        // Write miss does not allocate.
        do_write("wr1F00", 13'h1F00, 8'h11, 1);
        do_read("rd1F00", 13'h1F00, 1'b1, 2, 8'h11);
`ifdef CACHE_2WAY_STATS_EN
        check("cnt1:hit", hit_cnt, 32'd5);
        check("cnt1:miss", miss_cnt, 32'd6);
`endif

        // Reset in the middle of a refill.
        @(negedge clk);
        bus.addr_from_cpu = 13'h0A08;
        bus.rreq_from_cpu = 1'b1;
        cyc = 0;
        while (!bus.rreq_to_mem && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("rstmid:rreq_seen", 32'(bus.rreq_to_mem), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rstmid:rreq", 32'(bus.rreq_to_mem), 32'd0);
        check("rstmid:raddr", 32'(bus.raddr_to_mem), 32'd0);
        check("rstmid:hit", 32'(bus.hit_to_cpu), 32'd0);
`ifdef CACHE_2WAY_STATS_EN
        check("rstmid:miss_cnt", miss_cnt, 32'd0);
`endif
        @(negedge clk);
        bus.rreq_from_cpu = 1'b0;
        reset = 1'b0;
        do_read("rd0A08", 13'h0A08, 1'b1, 1, mem[13'h0A08]);
        // Valid bits were cleared; write-through data comes back from memory.
        do_read("rd0106r", 13'h0106, 1'b1, 2, 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
